au_sub_result_stage: RTL and testbench

//   Registered result stage directly downstream of the 4-bit combinational subtractor.
//   - Captures difference D and borrow each time the upstream valid/ready handshake completes.
//   - Derives zero, negative and signed-overflow flags from the captured result.
//   - Buffers the results in a DEPTH-entry FIFO and presents them to the consumer with a

---
 rtl/au_sub_result_stage.sv | 131 +++++++++++++
 tb/tb_au_sub_result_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/au_sub_result_stage.sv
// Registered result stage behind the subtractor: derives zero/neg/ovf flags and queues results in a small FIFO.
// Optional AU_STICKY_FLAGS_EN adds sticky borrow/overflow indicators with a clear input.
module au_sub_result_stage #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WIDTH-1:0]         in_d_i,
  input  logic                     in_borrow_i,
  input  logic                     in_a_msb_i,
  input  logic                     in_b_msb_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [WIDTH-1:0]         out_d_o,
  output logic                     out_borrow_o,
  output logic                     out_zero_o,
  output logic                     out_neg_o,
  output logic                     out_ovf_o,
`ifdef AU_STICKY_FLAGS_EN
  input  logic                     sticky_clr_i,
  output logic                     sticky_borrow_o,
  output logic                     sticky_ovf_o,
`endif
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             borrow;
    logic             zero;
    logic             neg;
    logic             ovf;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          last_q, last_d;
  entry_t          push_e, head;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  assign in_ready_o  = (count_q < FULL);
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    push_e        = '0;
    push_e.d      = in_d_i;
    push_e.borrow = in_borrow_i;
    push_e.zero   = (in_d_i == '0);
    push_e.neg    = in_d_i[WIDTH-1];
    push_e.ovf    = (in_a_msb_i != in_b_msb_i) && (in_d_i[WIDTH-1] != in_a_msb_i);
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    last_d  = last_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
      last_d = mem_q[rptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  // Storage needs no reset: it is only observed while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= push_e;
  end

  // Once drained, outputs keep showing the most recently popped entry.
  assign head         = (count_q != '0) ? mem_q[rptr_q] : last_q;
  assign out_d_o      = head.d;
  assign out_borrow_o = head.borrow;
  assign out_zero_o   = head.zero;
  assign out_neg_o    = head.neg;
  assign out_ovf_o    = head.ovf;
  assign count_o      = count_q;

`ifdef AU_STICKY_FLAGS_EN
  logic sticky_borrow_q, sticky_borrow_d, sticky_ovf_q, sticky_ovf_d;

  // A setting push beats a simultaneous clear.
  always_comb begin
    sticky_borrow_d = sticky_clr_i ? 1'b0 : sticky_borrow_q;
    sticky_ovf_d    = sticky_clr_i ? 1'b0 : sticky_ovf_q;
    if (push && push_e.borrow) sticky_borrow_d = 1'b1;
    if (push && push_e.ovf)    sticky_ovf_d    = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sticky_borrow_q <= 1'b0;
      sticky_ovf_q    <= 1'b0;
    end else begin
      sticky_borrow_q <= sticky_borrow_d;
      sticky_ovf_q    <= sticky_ovf_d;
    end
  end

  assign sticky_borrow_o = sticky_borrow_q;
  assign sticky_ovf_o    = sticky_ovf_q;
`endif
endmodule

// File: tb/tb_au_sub_result_stage.sv
// Scoreboard bench for au_sub_result_stage: driver pushes modelled results, monitor pops and compares.
module tb_au_sub_result_stage;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_ready;
  logic [3:0] in_d = '0;
  logic       in_borrow = 1'b0, in_a_msb = 1'b0, in_b_msb = 1'b0;
  logic       out_valid, out_ready = 1'b0;
  logic [3:0] out_d;
  logic       out_borrow, out_zero, out_neg, out_ovf;
  logic [1:0] count;
`ifdef AU_STICKY_FLAGS_EN
  logic       sticky_clr = 1'b0, sticky_borrow, sticky_ovf;
`endif

  au_sub_result_stage #(.WIDTH(4), .DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_d_i(in_d), .in_borrow_i(in_borrow), .in_a_msb_i(in_a_msb), .in_b_msb_i(in_b_msb),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_d_o(out_d), .out_borrow_o(out_borrow), .out_zero_o(out_zero),
    .out_neg_o(out_neg), .out_ovf_o(out_ovf),
`ifdef AU_STICKY_FLAGS_EN
    .sticky_clr_i(sticky_clr), .sticky_borrow_o(sticky_borrow), .sticky_ovf_o(sticky_ovf),
`endif
    .count_o(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d; int borrow; int zero; int neg; int ovf;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0;
  bit   mon_en = 1'b0;
  int   rdy_mode = 0;  // 0: hold off, 1: always accept, 2: random

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: results of A-B computed with plain integer arithmetic.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int sa, sb, sd;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    sd = sa - sb;
    e.d      = (a - b + 16) % 16;
    e.borrow = (a < b) ? 1 : 0;
    e.zero   = (e.d == 0) ? 1 : 0;
    e.neg    = (e.d >= 8) ? 1 : 0;
    e.ovf    = (sd > 7 || sd < -8) ? 1 : 0;
    return e;
  endfunction

  task automatic push_one(input int a, input int b);
    exp_t e;
    int   budget;
    e = model(a, b);
    @(negedge clk);
    in_valid  = 1'b1;
    in_d      = 4'(e.d);
    in_borrow = e.borrow[0];
    in_a_msb  = (a >= 8);
    in_b_msb  = (b >= 8);
    #2;
    budget = 0;
    while (!in_ready && budget < 50) begin
      chk("held_input_stable", int'(in_d), e.d);
      @(negedge clk); #2;
      budget++;
    end
    if (!in_ready) begin
      chk("push_timeout", 0, 1);
    end else begin
      q.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Monitor: samples 1 time unit after the falling edge, when the queue mirrors the DUT occupancy.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        out_ready = 1'b0;
        continue;
      end
      out_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      chk("count", int'(count), q.size());
      chk("out_valid", int'(out_valid), (q.size() != 0) ? 1 : 0);
      chk("in_ready", int'(in_ready), (q.size() < 2) ? 1 : 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("pop_from_empty_model", 1, 0);
        end else begin
          e = q.pop_front();
          chk("out_d", int'(out_d), e.d);
          chk("out_borrow", int'(out_borrow), e.borrow);
          chk("out_zero", int'(out_zero), e.zero);
          chk("out_neg", int'(out_neg), e.neg);
          chk("out_ovf", int'(out_ovf), e.ovf);
        end
      end
    end
  end

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    q.delete();
    rst = 1'b0;
    #2;
    chk("rst_count", int'(count), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_fields", int'({out_d, out_borrow, out_zero, out_neg, out_ovf}), 0);
`ifdef AU_STICKY_FLAGS_EN
    chk("rst_sticky", int'({sticky_borrow, sticky_ovf}), 0);
`endif
    mon_en = 1'b1;
  endtask

  task automatic drain();
    int budget;
    rdy_mode = 1;
    budget = 0;
    while (q.size() != 0 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    do_reset();

    // Directed vectors, consumer always ready.
    rdy_mode = 1;
    push_one(5, 3);
    push_one(3, 5);
    push_one(8, 1);
    push_one(9, 9);
    push_one(7, 15);
    drain();

    // Fill to full with the consumer stalled; third push must wait.
    rdy_mode = 0;
    push_one(1, 2);
    push_one(4, 4);
    @(negedge clk); #2;
    chk("full_count", int'(count), 2);
    chk("full_in_ready", int'(in_ready), 0);
    fork
      push_one(12, 3);
      begin repeat (3) @(negedge clk); rdy_mode = 1; end
    join
    drain();

    // Push and pop together at count=1 keeps count at 1.
    rdy_mode = 0;
    push_one(6, 2);
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) begin
      push_one(i, 3);
      chk("steady_count", int'(count), 1);
    end
    drain();

    // Reset with entries stored discards them.
    rdy_mode = 0;
    push_one(2, 9);
    push_one(11, 4);
    do_reset();

`ifdef AU_STICKY_FLAGS_EN
    rdy_mode = 1;
    push_one(3, 5);
    chk("sticky_borrow_set", int'(sticky_borrow), 1);
    push_one(5, 3);
    chk("sticky_borrow_hold", int'(sticky_borrow), 1);
    @(negedge clk); sticky_clr = 1'b1;
    @(posedge clk); #1; sticky_clr = 1'b0;
    chk("sticky_borrow_clr", int'(sticky_borrow), 0);
    sticky_clr = 1'b1;
    push_one(3, 5);
    sticky_clr = 1'b0;
    chk("sticky_set_wins", int'(sticky_borrow), 1);
    push_one(8, 1);
    chk("sticky_ovf_set", int'(sticky_ovf), 1);
    drain();
`endif

    // Randomized traffic with a randomly stalling consumer.
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      push_one(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    drain();

    mon_en = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
